midi_message_parser: RTL and testbench
======================================

# midi_message_parser

Byte-level MIDI parser that turns the raw byte stream from the UART receiver into the `MIDI::note_change_t` / `note_ready` event stream consumed by the synthesis pipeline, plus a control-change event stream for the parameter block. It tracks running status and filters on MIDI channel. It discards real-time, system-common, SysEx and unsupported channel messages without corrupting in-progress messages.

## Interface
- `OMNI`, default 0: 1 = accept all 16 channels; 0 = accept only `CHANNEL`.
- `CHANNEL`, default 0: 4-bit receive channel (0–15), used when `OMNI` = 0.

Ports:
- `clock_50_000_000`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `byte_data`  in  8  received MIDI byte.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` is valid in this cycle.
- `note`  out  `MIDI::note_change_t`  fields:
  - `status` (ON/OFF)
  - `note_number` (7 b)
  - `velocity` (7 b)
- `note_ready`  out  1  one-cycle pulse; `note` holds a new event.
- `cc_number`  out  7  controller number of the last accepted control change.
- `cc_value`  out  7  controller value of the last accepted control change.
- `cc_ready`  out  1  one-cycle pulse; `cc_number`/`cc_value` are new.

## Operation
- Byte classes:
  - Status byte: bit7 = 1.
  - Data byte: bit7 = 0.
  - Real-time byte: 0xF8–0xFF.
- Registers:
  - `running_status` (8 b; valid flag).
  - `data1` (7 b).
  - FSM state.
- FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Real-time bytes are ignored in every state. State and all registers are unchanged.
- Channel status 0x80–0xEF, from any state:
  - Loads `running_status`.
  - Goes to WAIT_D1 and abandons any partial message.
- 0xF0: clears running status, goes to SYSEX.
- 0xF1–0xF7: clear running status, go to IDLE. 0xF7 also ends SYSEX.
- SYSEX: data bytes are dropped. Only a status byte leaves the state.
- IDLE + data byte:
  - Running status valid: treat the byte as `data1` (go to WAIT_D2, or complete a one-data-byte message).
  - Running status not valid: drop the byte.
- WAIT_D1 + data byte:
  - Two-data-byte types (0x8n, 0x9n, 0xAn, 0xBn, 0xEn): store `data1`, go to WAIT_D2.
  - One-data-byte types (0xCn, 0xDn): message complete, discarded, go to IDLE.
- WAIT_D2 + data byte: message complete, go to IDLE; running status is retained.
- Completed message actions, only when the channel matches (OMNI or low nibble = `CHANNEL`):
  - 0x8n: `note` = {OFF, data1, data2}; pulse `note_ready`.
  - 0x9n, data2 ≠ 0: `note` = {ON, data1, data2}; pulse `note_ready`.
  - 0x9n, data2 = 0: `note` = {OFF, data1, 0}; pulse `note_ready`.
  - 0xBn: `cc_number` = data1, `cc_value` = data2; pulse `cc_ready`.
  - 0xAn, 0xEn: consumed, no output.
- Channel mismatch: the message is consumed normally (running status retained) but produces no output.
- `note` and `cc_*` hold their values between pulses.

## Timing
- Latency:
  - `note_ready`/`cc_ready` assert exactly 1 cycle after the `byte_valid` cycle of the completing data byte.
  - `note`/`cc_*` update in the same cycle as their pulse.
- Pulses last exactly 1 cycle.
- Back-to-back `byte_valid` every cycle is supported. No backpressure; every strobed byte is consumed.
- Reset (takes effect at the clock edge, mid-message included):
  - State to IDLE, running status invalid, `data1` = 0.
  - `note` = {OFF, 0, 0}.
  - `note_ready` = 0, `cc_number` = 0, `cc_value` = 0, `cc_ready` = 0.
  - A message whose last byte coincides with `reset` produces no pulse.
- `byte_valid` = 0: no state change.

## Test plan
- 0x90, 0x3C, 0x64 on channel 0 (`OMNI` = 0, `CHANNEL` = 0): one `note_ready` pulse 1 cycle after 0x64; `note` = {ON, 60, 100}.
- Running status: 0x90 0x3C 0x64 0x40 0x50 0x3C 0x00 gives three pulses:
  - {ON, 60, 100}
  - {ON, 64, 80}
  - {OFF, 60, 0}
- Real-time interleave: 0x80, 0xF8, 0x45, 0xFE, 0x20 gives exactly one pulse {OFF, 69, 32}; state is undisturbed.
- Channel filter (`CHANNEL` = 2): 0x91 0x3C 0x64 gives no pulse; 0x92 0x3C 0x64 gives a pulse. With `OMNI` = 1, both pulse.
- Abort and SysEx:
  - 0x90 0x3C 0xB0 0x07 0x7F gives only `cc_ready`, with `cc_number` = 7, `cc_value` = 127.
  - 0xF0 0x01 0x02 0xF7 0x3C 0x64 gives no pulses (running status cleared).
- Reset mid-message: 0x90 0x3C, then `reset` for 1 cycle, then 0x64 gives no pulse. All outputs read their reset values in the cycle after reset.

Source files
------------

// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: running status, channel filter, note on/off and
// control-change events; real-time, system and SysEx traffic is discarded.
package MIDI;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   note_number;
    logic [6:0]   velocity;
  } note_change_t;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} parser_state_t;
endpackage

module midi_message_parser #(
  parameter bit         OMNI    = 1'b0,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic                 clock_50_000_000,
  input  logic                 reset,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  output MIDI::note_change_t   note,
  output logic                 note_ready,
  output logic [6:0]           cc_number,
  output logic [6:0]           cc_value,
  output logic                 cc_ready,
  output MIDI::parser_state_t  debug_state
);

  // Handshake: byte_valid is a one-cycle strobe with no ready/backpressure;
  // every strobed byte is consumed in its own cycle, so bytes may arrive
  // back to back. note_ready/cc_ready are one-cycle pulses, payload held.

  MIDI::parser_state_t state;
  logic [7:0]          running_status;
  logic                running_valid;
  logic [6:0]          data1;

  logic       is_realtime;
  logic       is_status;
  logic       one_byte_type;
  logic       channel_match;
  logic [6:0] data7;

  assign is_realtime   = (byte_data[7:3] == 5'b11111);
  assign is_status     = byte_data[7];
  assign data7         = byte_data[6:0];
  // 0xCn and 0xDn carry a single data byte.
  assign one_byte_type = (running_status[7:5] == 3'b110);
  assign channel_match = OMNI || (running_status[3:0] == CHANNEL);
  assign debug_state   = state;

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state          <= MIDI::IDLE;
      running_status <= 8'h00;
      running_valid  <= 1'b0;
      data1          <= 7'd0;
      note           <= '{MIDI::OFF, 7'd0, 7'd0};
      note_ready     <= 1'b0;
      cc_number      <= 7'd0;
      cc_value       <= 7'd0;
      cc_ready       <= 1'b0;
    end else begin
      note_ready <= 1'b0;
      cc_ready   <= 1'b0;
      if (byte_valid && !is_realtime) begin
        if (is_status) begin
          if (byte_data < 8'hF0) begin
            running_status <= byte_data;
            running_valid  <= 1'b1;
            state          <= MIDI::WAIT_D1;
          end else if (byte_data == 8'hF0) begin
            running_valid <= 1'b0;
            state         <= MIDI::SYSEX;
          end else begin
            running_valid <= 1'b0;
            state         <= MIDI::IDLE;
          end
        end else begin
          case (state)
            MIDI::IDLE, MIDI::WAIT_D1: begin
              if (running_valid) begin
                if (one_byte_type) begin
                  state <= MIDI::IDLE;
                end else begin
                  data1 <= data7;
                  state <= MIDI::WAIT_D2;
                end
              end
            end
            MIDI::WAIT_D2: begin
              state <= MIDI::IDLE;
              if (channel_match) begin
                case (running_status[7:4])
                  4'h8: begin
                    note       <= '{MIDI::OFF, data1, data7};
                    note_ready <= 1'b1;
                  end
                  4'h9: begin
                    // Velocity 0 is the running-status form of note off.
                    if (data7 != 7'd0) note <= '{MIDI::ON, data1, data7};
                    else               note <= '{MIDI::OFF, data1, 7'd0};
                    note_ready <= 1'b1;
                  end
                  4'hB: begin
                    cc_number <= data1;
                    cc_value  <= data7;
                    cc_ready  <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: three instances (channel 0,
// channel 2, omni) share one byte stream; note events go through a scoreboard.
module tb_midi_message_parser;

  logic       clk;
  logic       reset;
  logic [7:0] byte_data;
  logic       byte_valid;

  MIDI::note_change_t  note0, note2, noteo;
  logic                ready0, ready2, readyo;
  logic [6:0]          ccn0, ccv0, ccn2, ccv2, ccno, ccvo;
  logic                ccr0, ccr2, ccro;
  MIDI::parser_state_t st0, st2, sto;

  midi_message_parser #(.OMNI(1'b0), .CHANNEL(4'd0)) dut0 (
    .clock_50_000_000(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(note0), .note_ready(ready0), .cc_number(ccn0), .cc_value(ccv0), .cc_ready(ccr0),
    .debug_state(st0));

  midi_message_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut2 (
    .clock_50_000_000(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(note2), .note_ready(ready2), .cc_number(ccn2), .cc_value(ccv2), .cc_ready(ccr2),
    .debug_state(st2));

  midi_message_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_omni (
    .clock_50_000_000(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(noteo), .note_ready(readyo), .cc_number(ccno), .cc_value(ccvo), .cc_ready(ccro),
    .debug_state(sto));

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_note0 = 0, n_note2 = 0, n_noteo = 0, n_cc0 = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at the next negedge.
  task automatic send(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard for the channel-0 instance plus pulse counters.
  always @(negedge clk) begin
    if (ready0) begin
      n_note0++;
      check("note_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("note_event", note0, exp_q.pop_front());
    end
    if (ready2) n_note2++;
    if (readyo) n_noteo++;
    if (ccr0)   n_cc0++;
  end

  int b0, b2, bo, bc;

  task automatic mark();
    b0 = n_note0; b2 = n_note2; bo = n_noteo; bc = n_cc0;
  endtask

  initial begin
    reset = 1'b1; byte_data = 8'h00; byte_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_note", note0, 0);
    check("rst_note_ready", ready0, 0);
    check("rst_cc_number", ccn0, 0);
    check("rst_cc_value", ccv0, 0);
    check("rst_cc_ready", ccr0, 0);
    check("rst_state", st0, MIDI::IDLE);

    // Basic note on, exact latency and pulse width
    mark();
    exp_q.push_back({1'b1, 7'd60, 7'd100});
    send(8'h90); send(8'h3C);
    check("wait_d2_state", st0, MIDI::WAIT_D2);
    check("no_early_pulse", ready0, 0);
    send(8'h64);
    check("note_on_ready", ready0, 1);
    check("note_on_value", note0, {1'b1, 7'd60, 7'd100});
    idle(1);
    check("note_pulse_width", ready0, 0);
    check("note_hold", note0, {1'b1, 7'd60, 7'd100});
    check("idle_after_msg", st0, MIDI::IDLE);

    // Running status, back to back, velocity 0 as note off
    mark();
    exp_q.push_back({1'b1, 7'd60, 7'd100});
    exp_q.push_back({1'b1, 7'd64, 7'd80});
    exp_q.push_back({1'b0, 7'd60, 7'd0});
    send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50); send(8'h3C); send(8'h00);
    check("vel0_note_off", note0, {1'b0, 7'd60, 7'd0});
    idle(2);
    check("running_count", n_note0 - b0, 3);
    check("running_drained", exp_q.size(), 0);

    // Real-time bytes interleaved mid-message
    mark();
    exp_q.push_back({1'b0, 7'd69, 7'd32});
    send(8'h80); send(8'hF8);
    check("rt_state_d1", st0, MIDI::WAIT_D1);
    send(8'h45); send(8'hFE);
    check("rt_state_d2", st0, MIDI::WAIT_D2);
    send(8'h20);
    check("rt_note_off", note0, {1'b0, 7'd69, 7'd32});
    idle(2);
    check("rt_count", n_note0 - b0, 1);
    check("rt_drained", exp_q.size(), 0);

    // Channel filter
    mark();
    send(8'h91); send(8'h3C); send(8'h64);
    send(8'h92); send(8'h3C); send(8'h64);
    idle(2);
    check("ch0_filtered", n_note0 - b0, 0);
    check("ch2_count", n_note2 - b2, 1);
    check("omni_count", n_noteo - bo, 2);
    check("ch2_value", note2, {1'b1, 7'd60, 7'd100});
    check("ch0_note_held", note0, {1'b0, 7'd69, 7'd32});

    // Abort of a partial note by a control change
    mark();
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h7F);
    check("cc_ready", ccr0, 1);
    check("cc_number", ccn0, 7);
    check("cc_value", ccv0, 127);
    idle(2);
    check("cc_pulse_width", ccr0, 0);
    check("cc_hold", ccn0, 7);
    check("abort_no_note", n_note0 - b0, 0);
    check("cc_count", n_cc0 - bc, 1);

    // SysEx clears running status
    mark();
    send(8'hF0); send(8'h01);
    check("sysex_state", st0, MIDI::SYSEX);
    send(8'h02); send(8'hF7);
    check("sysex_end_state", st0, MIDI::IDLE);
    send(8'h3C); send(8'h64);
    idle(2);
    check("sysex_no_note", n_note0 - b0, 0);
    check("sysex_no_cc", n_cc0 - bc, 0);
    check("sysex_no_omni", n_noteo - bo, 0);

    // One-data-byte messages and aftertouch produce nothing
    mark();
    send(8'hC0); send(8'h05); send(8'h06);
    check("prog_state", st0, MIDI::IDLE);
    send(8'hA0); send(8'h3C); send(8'h64);
    idle(2);
    check("onebyte_no_note", n_noteo - bo, 0);
    check("onebyte_no_cc", n_cc0 - bc, 0);

    // Reset mid-message
    mark();
    send(8'h90); send(8'h3C);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("mid_rst_note", note0, 0);
    check("mid_rst_cc_number", ccn0, 0);
    check("mid_rst_cc_value", ccv0, 0);
    check("mid_rst_state", st0, MIDI::IDLE);
    send(8'h64);
    idle(2);
    check("mid_rst_no_pulse", n_note0 - b0, 0);

    // Completing byte coincident with reset
    mark();
    send(8'h90); send(8'h3C);
    reset = 1'b1;
    send(8'h64);
    reset = 1'b0;
    idle(2);
    check("rst_coincide_no_pulse", n_noteo - bo, 0);
    check("rst_coincide_state", sto, MIDI::IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
